gen_sample_scheduler: RTL and testbench
=======================================

GEN_SAMPLE_SCHEDULER -- requirements
Module: gen_sample_scheduler

Interface
REQ-001 Parameter DATA_W, 24, sample width; matches the generator's data_out.
REQ-002 Parameter DIV_W, 16, width of rate divider and burst length.
REQ-003 Parameter FIFO_DEPTH, 4, output buffer depth in samples (power of two).
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 start  in  1  single-cycle start command.
REQ-008 stop  in  1  single-cycle stop command.
REQ-009 burst_mode  in  1  0 = continuous run, 1 = burst of burst_len samples.
REQ-010 burst_len  in  DIV_W  samples per burst; latched at start.
REQ-011 rate_div  in  DIV_W  sample period minus one in clk cycles; latched at start.
REQ-012 gen_data  in  DATA_W  generator sample, valid one cycle after gen_en.
REQ-013 gen_en  out  1  single-cycle request to the generator for one new sample.
REQ-014 s_valid  out  1  downstream sample available.
REQ-015 s_data  out  DATA_W  downstream sample (FIFO head).
REQ-016 s_ready  in  1  downstream accepts sample.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 done  out  1  single-cycle pulse on return to IDLE from DRAIN.
REQ-019 overflow_cnt  out  8  dropped-sample counter, saturating.

Function
REQ-020 States IDLE, RUN, BURST and DRAIN SHALL be used; one state is active at a time.
REQ-021 IDLE->RUN SHALL occur on start with burst_mode=0; IDLE->BURST on start with burst_mode=1 and burst_len>0; start with burst_mode=1 and burst_len=0 SHALL be ignored.
REQ-022 start and stop asserted together in IDLE SHALL leave the block in IDLE; start outside IDLE SHALL be ignored.
REQ-023 In RUN and BURST, gen_en SHALL pulse on the first cycle after entry and then every rate_div+1 cycles; rate_div=0 gives a pulse every cycle.
REQ-024 RUN->DRAIN SHALL occur on stop; no gen_en is issued in the stop cycle or later.
REQ-025 BURST->DRAIN SHALL occur on the cycle of the burst_len-th gen_en, or on stop, whichever is first.
REQ-026 The sample SHALL be captured from gen_data into the FIFO exactly one cycle after each gen_en, including a capture that falls in DRAIN.
REQ-027 DRAIN->IDLE SHALL occur when the FIFO is empty and no capture is pending; done pulses on that cycle.
REQ-028 s_valid SHALL equal FIFO not-empty; s_data SHALL be the oldest sample; pop on s_valid && s_ready.
REQ-029 The output order SHALL match capture order, with no duplication.
REQ-030 A capture into a full FIFO SHALL be accepted if a pop occurs in the same cycle; otherwise the sample is dropped and overflow_cnt increments.
REQ-031 overflow_cnt SHALL saturate at 255 and clear only on reset.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy counter.
REQ-033 rate_div and burst_len SHALL be latched at start; input changes during operation have no effect.

Reset
REQ-034 While reset=0 at a clk edge, the state SHALL become IDLE; gen_en, s_valid, busy, done and overflow_cnt are 0; s_data is 0; FIFO is empty; the divider and burst counters are 0.
REQ-035 Reset mid-operation SHALL discard all buffered samples and any pending capture, with no done pulse.

Structure
REQ-036 Package gen_sched_pkg SHALL hold the state encoding (IDLE, RUN, BURST, DRAIN) and the defaults for DATA_W, DIV_W and FIFO_DEPTH.
REQ-037 The FIFO SHALL be one sub-module, sample_fifo (DATA_W, FIFO_DEPTH), with push/pop/full/empty; the FSM, divider and burst counter stay in the top level.

Verification
REQ-038 Continuous run: rate_div=9, s_ready=1, start, stop after 100 cycles -> gen_en every 10 cycles; 10 samples out in order; done 1 cycle after the last pop.
REQ-039 Burst: burst_mode=1, burst_len=5, rate_div=0 -> exactly 5 consecutive gen_en pulses; 5 samples out; DRAIN then IDLE; one done pulse.
REQ-040 Backpressure: rate_div=0, s_ready=0, burst_len=10 -> FIFO holds the first 4 samples; overflow_cnt=6; after s_ready=1, 4 samples out, then done.
REQ-041 Full with simultaneous pop: FIFO full, s_ready=1, capture in the same cycle -> no drop; overflow_cnt unchanged.
REQ-042 Edge commands: start with burst_mode=1 and burst_len=0 -> stays IDLE; start with stop in IDLE -> stays IDLE; reset=0 in RUN with 3 buffered samples -> next cycle IDLE, s_valid=0, no done.
REQ-043 Saturation: 300 forced drops -> overflow_cnt=255.

Source files
------------

// File: rtl/gen_sched_pkg.sv
// Shared state encoding and parameter defaults for the sample scheduler.
package gen_sched_pkg;
  localparam int unsigned DATA_W_DEF     = 24;
  localparam int unsigned DIV_W_DEF      = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2,
    DRAIN = 2'd3
  } state_e;
endpackage

// File: rtl/sample_fifo.sv
// Output sample buffer; a push into a full FIFO is taken only if a pop happens in the same cycle.
module sample_fifo
  import gen_sched_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic              wr_en, rd_en;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (wr_en) wr_d = wr_q + (AW+1)'(1);
    if (rd_en) rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/gen_sample_scheduler.sv
// Paces generator requests (continuous or burst), captures returned samples and buffers them downstream.
module gen_sample_scheduler
  import gen_sched_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DIV_W      = DIV_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              burst_mode,
  input  logic [DIV_W-1:0]  burst_len,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [DATA_W-1:0] gen_data,
  output logic              gen_en,
  output logic              s_valid,
  output logic [DATA_W-1:0] s_data,
  input  logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        overflow_cnt
);
  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d, burst_q, burst_d, rate_q, rate_d, blen_q, blen_d;
  logic [7:0]        ovf_q, ovf_d;
  logic              cap_q;
  logic              fifo_full, fifo_empty, pop, drop;

  sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (cap_q),
    .data_i  (gen_data),
    .pop_i   (pop),
    .data_o  (s_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign s_valid      = !fifo_empty;
  assign pop          = s_valid && s_ready;
  assign drop         = cap_q && fifo_full && !pop;
  assign busy         = (state_q != IDLE);
  assign overflow_cnt = ovf_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    burst_d = burst_q;
    rate_d  = rate_q;
    blen_d  = blen_q;
    gen_en  = 1'b0;
    done    = 1'b0;
    ovf_d   = (drop && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start && !stop && (!burst_mode || burst_len != '0)) begin
          rate_d  = rate_div;
          blen_d  = burst_len;
          state_d = burst_mode ? BURST : RUN;
        end
      end
      RUN, BURST: begin
        if (stop) begin
          state_d = DRAIN;
        end else begin
          gen_en = (div_q == '0);
          div_d  = (div_q == rate_q) ? '0 : div_q + DIV_W'(1);
          if (state_q == BURST && gen_en) begin
            burst_d = burst_q + DIV_W'(1);
            if (burst_q == blen_q - DIV_W'(1)) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty && !cap_q) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Counters restart from zero on every entry to RUN/BURST.
    if (state_d == IDLE || state_d == DRAIN) begin
      div_d   = '0;
      burst_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      burst_q <= '0;
      rate_q  <= '0;
      blen_q  <= '0;
      ovf_q   <= '0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      burst_q <= burst_d;
      rate_q  <= rate_d;
      blen_q  <= blen_d;
      ovf_q   <= ovf_d;
      cap_q   <= gen_en;
    end
  end
endmodule

// File: tb/tb_gen_sample_scheduler.sv
// Scoreboard bench: directed scenarios push expected samples; a monitor pops and compares on each transfer.
module tb_gen_sample_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, stop = 1'b0, burst_mode = 1'b0, s_ready = 1'b0;
  logic [15:0] burst_len = '0, rate_div = '0;
  logic [23:0] gen_data = '0;
  logic        gen_en, s_valid, busy, done;
  logic [23:0] s_data;
  logic [7:0]  overflow_cnt;

  int          checks = 0, passed = 0;
  int          cyc = 0, done_cnt = 0, done_cyc = 0, last_pop_cyc = 0;
  logic [15:0] gen_idx = '0;
  int          gen_times[$];
  logic [23:0] exp_q[$];

  gen_sample_scheduler #(.DATA_W(24), .DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .burst_mode(burst_mode),
    .burst_len(burst_len), .rate_div(rate_div), .gen_data(gen_data), .gen_en(gen_en),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .busy(busy), .done(done),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  // Generator model: a registered sample appears the cycle after each request.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gen_en) begin
      gen_data <= {8'h5A, gen_idx};
      gen_idx  <= gen_idx + 16'd1;
      gen_times.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (reset && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (reset && s_valid && s_ready) begin
      last_pop_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sample_unexpected: got %06h required none", s_data);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if (s_data === e) passed++;
        else $display("FAIL sample_order: got %06h required %06h", s_data, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({8'h5A, 16'(base + i)});
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      $display("FAIL idle_timeout: got busy=1 required busy=0 within %0d cycles", lim);
    end
    tick();
  endtask

  task automatic go(input logic bm, input int blen, input int rdiv);
    burst_mode = bm;
    burst_len  = 16'(blen);
    rate_div   = 16'(rdiv);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    int base, nt, d0;
    #2_000_000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

  initial begin
    int base, nt, d0;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_gen_en", gen_en, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow_cnt, 0);
    chk("rst_sdata", s_data, 0);
    reset = 1'b1;
    tick(2);

    // Continuous run, rate 9; rate_div changes after start must not matter.
    base = int'(gen_idx); nt = gen_times.size(); d0 = done_cnt;
    s_ready = 1'b1;
    push_exp(base, 10);
    go(1'b0, 0, 9);
    rate_div = 16'd3;
    chk("run_busy", busy, 1);
    tick(99);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle(50);
    chk("run_gen_count", gen_times.size() - nt, 10);
    chk("run_gen_span", gen_times[nt + 9] - gen_times[nt], 90);
    chk("run_done_pulses", done_cnt - d0, 1);
    chk("run_sb_empty", exp_q.size(), 0);

    // Burst of 5 at full rate.
    base = int'(gen_idx); nt = gen_times.size(); d0 = done_cnt;
    push_exp(base, 5);
    go(1'b1, 5, 0);
    wait_idle(50);
    chk("burst_gen_count", gen_times.size() - nt, 5);
    chk("burst_gen_span", gen_times[nt + 4] - gen_times[nt], 4);
    chk("burst_done_pulses", done_cnt - d0, 1);
    chk("burst_done_latency", done_cyc - last_pop_cyc, 1);
    chk("burst_sb_empty", exp_q.size(), 0);

    // Backpressure: 10 captures into a 4-deep FIFO.
    base = int'(gen_idx); d0 = done_cnt;
    s_ready = 1'b0;
    push_exp(base, 4);
    go(1'b1, 10, 0);
    tick(14);
    chk("bp_ovf", overflow_cnt, 6);
    chk("bp_valid", s_valid, 1);
    chk("bp_draining", busy, 1);
    s_ready = 1'b1;
    wait_idle(50);
    chk("bp_done_pulses", done_cnt - d0, 1);
    chk("bp_done_latency", done_cyc - last_pop_cyc, 1);
    chk("bp_sb_empty", exp_q.size(), 0);

    // Capture into a full FIFO on the same cycle as a pop.
    base = int'(gen_idx);
    s_ready = 1'b0;
    push_exp(base, 5);
    go(1'b1, 5, 0);
    tick(5);
    s_ready = 1'b1;
    wait_idle(50);
    chk("fullpop_ovf", overflow_cnt, 6);
    chk("fullpop_sb_empty", exp_q.size(), 0);

    // Edge commands.
    nt = gen_times.size();
    go(1'b1, 0, 0);
    chk("zero_burst_busy", busy, 0);
    tick(2);
    chk("zero_burst_no_gen", gen_times.size() - nt, 0);
    stop = 1'b1;
    go(1'b0, 0, 0);
    stop = 1'b0;
    chk("start_stop_busy", busy, 0);

    // Reset mid-run with 3 buffered samples.
    d0 = done_cnt;
    s_ready = 1'b0;
    go(1'b0, 0, 0);
    tick(4);
    chk("mid_valid_before", s_valid, 1);
    reset = 1'b0;
    tick();
    chk("mid_busy", busy, 0);
    chk("mid_valid", s_valid, 0);
    chk("mid_done", done, 0);
    chk("mid_ovf", overflow_cnt, 0);
    reset = 1'b1;
    tick(2);
    chk("mid_valid_after", s_valid, 0);
    chk("mid_sdata_after", s_data, 0);
    chk("mid_no_done", done_cnt - d0, 0);

    // Saturation: 304 captures, 300 dropped.
    base = int'(gen_idx);
    push_exp(base, 4);
    go(1'b1, 304, 0);
    tick(310);
    chk("sat_ovf", overflow_cnt, 255);
    s_ready = 1'b1;
    wait_idle(50);
    chk("sat_ovf_hold", overflow_cnt, 255);
    chk("sat_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
